mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage between EX and the register file.
- Accepts one instruction at a time from EX. Loads and stores run on the data bus using a request/grant/rvalid handshake.
- Produces the registered mem2regs_* writeback triple that the register file consumes.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
TIMEOUT_CYCLES, 64, bus cycles allowed in REQ or WAIT before abort; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock; all state updates on rising edge
rest  input  1  reset; asynchronous, active-low
ex2mem_valid_i  input  1  EX presents an instruction
ex2mem_ready_o  output  1  stage can accept; high only in IDLE
ex2mem_is_load_i  input  1  instruction is a load
ex2mem_is_store_i  input  1  instruction is a store
ex2mem_funct3_i  input  3  RISC-V funct3 (access size and sign)
ex2mem_result_i  input  32  ALU result, or effective address for load/store
ex2mem_store_data_i  input  32  rs2 value for stores
ex2mem_rd_i  input  5  destination register
ex2mem_wb_en_i  input  1  instruction writes rd
mem_req_o  output  1  bus request
mem_we_o  output  1  1 = write
mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  output  32  lane-replicated store data
mem_wstrb_o  output  4  byte strobes
mem_gnt_i  input  1  bus accepted the request
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  32  read data
mem2regs_wb_en_o  output  1  writeback pulse
mem2regs_rd_o  output  5  writeback register
mem2regs_rd_data_o  output  32  writeback data
mem_err_o  output  1  one-cycle pulse on misalign, illegal funct3, or timeout
mem_err_addr_o  output  32  offending address; valid while mem_err_o is high

Behaviour:
- Reset (rest low, asynchronous):
  - State goes to IDLE and the timeout counter clears.
  - Every output register clears to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, all mem2regs_*, mem_err_o, mem_err_addr_o.
  - ex2mem_ready_o is 1 while in IDLE.
  - Reset mid-transaction drops mem_req_o immediately; the pending load produces no writeback.
- FSM states and transitions:
  - IDLE: accept when ex2mem_valid_i && ex2mem_ready_o.
  - Non-memory op: next cycle mem2regs_wb_en_o = wb_en_i && (rd != 0), rd_data = result. Stay in IDLE.
  - Load/store, legal and aligned: latch the bus fields, go to REQ. mem_req_o rises the cycle after accept.
  - Misaligned access (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0) or illegal funct3: next cycle mem_err_o = 1 and mem_err_addr_o = result. No bus request, no writeback, stay in IDLE.
  - REQ: mem_req_o = 1; addr, we, wdata and wstrb are held stable until mem_gnt_i.
    - On gnt, store: go to IDLE, no writeback.
    - On gnt, load: go to WAIT.
    - On gnt && rvalid in the same cycle: complete the load directly and go to IDLE.
    - mem_req_o drops in the cycle after gnt.
  - WAIT: mem_req_o = 0. On mem_rvalid_i, extract and extend the data, register the writeback, go to IDLE.
- Load extract, using byte offset = addr[1:0]:
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend halfword at addr[1].
  - 101 LHU: zero-extend halfword at addr[1].
  - 010 LW: full word.
- Store encoding:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 0011 << addr[1:0]; wdata = half replicated ×2.
  - SW: wstrb = 1111.
  - Loads drive wstrb = 0000 and we = 0.
- Writeback:
  - mem2regs_wb_en_o is a single-cycle pulse, registered, one cycle after completion (accept for ALU ops, rvalid for loads).
  - rd = 0 suppresses the pulse; rd and data are still driven.
  - rd and rd_data hold their last value when wb_en_o = 0.
- Timeout:
  - Counter clears on entry to REQ and counts each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES (if nonzero): mem_err_o pulse, mem_err_addr_o = latched address, mem_req_o drops, go to IDLE, no writeback.
  - Late rvalid/gnt arriving in IDLE is ignored.
- Throughput:
  - At most one outstanding transaction.
  - An ALU op accepted in IDLE does not block the next; back-to-back acceptance is allowed, one instruction per cycle.
- Both is_load and is_store high: treated as illegal, error pulse.

Test Plan:
- ALU passthrough: result=0x12345678, rd=5, wb_en=1 → next cycle wb_en_o=1, rd_o=5, data=0x12345678; repeat with rd=0 → wb_en_o stays 0.
- LB at 0x1003, rdata=0x80FF_0000, gnt and rvalid one cycle apart → mem_addr_o=0x1000, writeback 0xFFFFFF80; LBU same stimulus → 0x00000080.
- SH at 0x2002, store_data=0xAAAA_BEEF, gnt held low 3 cycles → req stays high with stable fields: wstrb=1100, wdata=0xBEEFBEEF; no writeback; ready returns 1 the cycle after gnt.
- LW at 0x3001 → no mem_req_o, mem_err_o pulse with mem_err_addr_o=0x3001, no writeback.
- TIMEOUT_CYCLES=4, load granted, rvalid never arrives → err pulse after 4 cycles, FSM in IDLE, late rvalid ignored, no writeback.
- rest driven low while in WAIT → mem_req_o and all outputs 0 asynchronously; after release, an ALU op completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and the register file.
// Accepts one instruction at a time, runs loads/stores over a
// req/gnt/rvalid bus and produces a registered writeback triple.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rest,
   input  logic        ex2mem_valid_i,
   output logic        ex2mem_ready_o,
   input  logic        ex2mem_is_load_i,
   input  logic        ex2mem_is_store_i,
   input  logic [2:0]  ex2mem_funct3_i,
   input  logic [31:0] ex2mem_result_i,
   input  logic [31:0] ex2mem_store_data_i,
   input  logic [4:0]  ex2mem_rd_i,
   input  logic        ex2mem_wb_en_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem2regs_wb_en_o,
   output logic [4:0]  mem2regs_rd_o,
   output logic [31:0] mem2regs_rd_data_o,
   output logic        mem_err_o,
   output logic [31:0] mem_err_addr_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Last counter value before the abort fires; the abort happens at the
   // end of the TIMEOUT_CYCLES-th cycle spent in REQ or WAIT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [31:0]       addr_full, addr_full_nxt;
   logic [2:0]        funct3_q, funct3_nxt;
   logic [4:0]        rd_q, rd_nxt;
   logic              wb_q, wb_q_nxt;

   logic              req_nxt, we_nxt;
   logic [31:0]       addr_nxt, wdata_nxt;
   logic [3:0]        wstrb_nxt;
   logic              wb_en_nxt;
   logic [4:0]        wb_rd_nxt;
   logic [31:0]       wb_data_nxt;
   logic              err_nxt;
   logic [31:0]       err_addr_nxt;

   logic              timeout_hit;
   logic              bad_access;
   logic              is_mem;
   logic [35:0]       store_enc;
   logic [31:0]       load_data;

   // Rejects illegal funct3, misaligned addresses and load+store together.
   function automatic logic access_bad(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3)
         3'b000, 3'b100: bad = 1'b0;
         3'b001, 3'b101: bad = off[0];
         3'b010:         bad = |off;
         default:        bad = 1'b1;
      endcase
      if (st && f3[2]) bad = 1'b1;
      if (ld && st)    bad = 1'b1;
      return bad;
   endfunction

   // Store encoding: {wstrb, wdata} with the data replicated across lanes.
   function automatic logic [35:0] store_encode(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] d);
      logic [3:0] strb;
      case (f3[1:0])
         2'b00: begin
            strb = 4'b0001 << off;
            return {strb, {4{d[7:0]}}};
         end
         2'b01: begin
            strb = 4'b0011 << off;
            return {strb, {2{d[15:0]}}};
         end
         default: return {4'b1111, d};
      endcase
   endfunction

   // Load extraction: select the addressed byte/half and extend it.
   function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] d);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      sh = d >> {off, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (f3)
         3'b000: begin
            ext = b;
            return ext;
         end
         3'b001: begin
            ext = h;
            return ext;
         end
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return d;
      endcase
   endfunction

   assign ex2mem_ready_o = (state == S_IDLE);
   assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
   assign is_mem         = ex2mem_is_load_i | ex2mem_is_store_i;
   assign bad_access     = access_bad(ex2mem_is_load_i, ex2mem_is_store_i,
                                      ex2mem_funct3_i, ex2mem_result_i[1:0]);
   assign store_enc      = store_encode(ex2mem_funct3_i, ex2mem_result_i[1:0],
                                        ex2mem_store_data_i);
   assign load_data      = load_extract(funct3_q, addr_full[1:0], mem_rdata_i);

   // Next-state and next-output logic; every register holds by default,
   // pulses (writeback, error) default low.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      addr_full_nxt = addr_full;
      funct3_nxt    = funct3_q;
      rd_nxt        = rd_q;
      wb_q_nxt      = wb_q;
      req_nxt       = mem_req_o;
      we_nxt        = mem_we_o;
      addr_nxt      = mem_addr_o;
      wdata_nxt     = mem_wdata_o;
      wstrb_nxt     = mem_wstrb_o;
      wb_en_nxt     = 1'b0;
      wb_rd_nxt     = mem2regs_rd_o;
      wb_data_nxt   = mem2regs_rd_data_o;
      err_nxt       = 1'b0;
      err_addr_nxt  = mem_err_addr_o;

      case (state)
         S_IDLE: begin
            if (ex2mem_valid_i) begin
               if (!is_mem) begin
                  wb_en_nxt   = ex2mem_wb_en_i && (ex2mem_rd_i != 5'd0);
                  wb_rd_nxt   = ex2mem_rd_i;
                  wb_data_nxt = ex2mem_result_i;
               end else if (bad_access) begin
                  err_nxt      = 1'b1;
                  err_addr_nxt = ex2mem_result_i;
               end else begin
                  state_nxt     = S_REQ;
                  cnt_nxt       = '0;
                  req_nxt       = 1'b1;
                  we_nxt        = ex2mem_is_store_i;
                  addr_nxt      = {ex2mem_result_i[31:2], 2'b00};
                  addr_full_nxt = ex2mem_result_i;
                  funct3_nxt    = ex2mem_funct3_i;
                  rd_nxt        = ex2mem_rd_i;
                  wb_q_nxt      = ex2mem_wb_en_i;
                  if (ex2mem_is_store_i) begin
                     wstrb_nxt = store_enc[35:32];
                     wdata_nxt = store_enc[31:0];
                  end else begin
                     wstrb_nxt = 4'b0000;
                     wdata_nxt = 32'd0;
                  end
               end
            end
         end

         S_REQ: begin
            if (mem_gnt_i) begin
               req_nxt = 1'b0;
               if (mem_we_o) begin
                  state_nxt = S_IDLE;
               end else if (mem_rvalid_i) begin
                  state_nxt   = S_IDLE;
                  wb_en_nxt   = wb_q && (rd_q != 5'd0);
                  wb_rd_nxt   = rd_q;
                  wb_data_nxt = load_data;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = cnt + CNT_W'(1);
               end
            end else if (timeout_hit) begin
               state_nxt    = S_IDLE;
               req_nxt      = 1'b0;
               err_nxt      = 1'b1;
               err_addr_nxt = addr_full;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_WAIT: begin
            if (mem_rvalid_i) begin
               state_nxt   = S_IDLE;
               wb_en_nxt   = wb_q && (rd_q != 5'd0);
               wb_rd_nxt   = rd_q;
               wb_data_nxt = load_data;
            end else if (timeout_hit) begin
               state_nxt    = S_IDLE;
               err_nxt      = 1'b1;
               err_addr_nxt = addr_full;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = S_IDLE;
            req_nxt   = 1'b0;
         end
      endcase
   end

   // State, transaction latches and all registered outputs; reset clears all.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state              <= S_IDLE;
         cnt                <= '0;
         addr_full          <= 32'd0;
         funct3_q           <= 3'd0;
         rd_q               <= 5'd0;
         wb_q               <= 1'b0;
         mem_req_o          <= 1'b0;
         mem_we_o           <= 1'b0;
         mem_addr_o         <= 32'd0;
         mem_wdata_o        <= 32'd0;
         mem_wstrb_o        <= 4'd0;
         mem2regs_wb_en_o   <= 1'b0;
         mem2regs_rd_o      <= 5'd0;
         mem2regs_rd_data_o <= 32'd0;
         mem_err_o          <= 1'b0;
         mem_err_addr_o     <= 32'd0;
      end else begin
         state              <= state_nxt;
         cnt                <= cnt_nxt;
         addr_full          <= addr_full_nxt;
         funct3_q           <= funct3_nxt;
         rd_q               <= rd_nxt;
         wb_q               <= wb_q_nxt;
         mem_req_o          <= req_nxt;
         mem_we_o           <= we_nxt;
         mem_addr_o         <= addr_nxt;
         mem_wdata_o        <= wdata_nxt;
         mem_wstrb_o        <= wstrb_nxt;
         mem2regs_wb_en_o   <= wb_en_nxt;
         mem2regs_rd_o      <= wb_rd_nxt;
         mem2regs_rd_data_o <= wb_data_nxt;
         mem_err_o          <= err_nxt;
         mem_err_addr_o     <= err_addr_nxt;
      end
   end

endmodule
